// File: rtl/measure_fifo.sv
// measure_fifo: first-word-fall-through result FIFO behind the frequency-meter measure stage.
// Build option MEASURE_FIFO_DROP_OLDEST_EN: on overflow, overwrite the oldest entry instead of dropping the newest.
module measure_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          reg_wr_en_i,
    input  logic [63:0]   reg_wr_data_i,
    input  logic          clr_i,
    input  logic          rd_ready_i,
    output logic          rd_valid_o,
    output logic [63:0]   rd_data_o,
    output logic [AW:0]   level_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          ovf_o
);

    localparam int DATA_W = 64;
    localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LEVEL_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic          ovf;

    logic full;
    logic empty;
    logic pop;
    logic overflow;
    logic wr_fire;
    logic rd_adv;

    // Flags come from the level register so a full FIFO is never confused with an empty one.
    assign full  = (level == LEVEL_FULL);
    assign empty = (level == '0);

    always_comb begin
        pop      = 1'b0;
        overflow = 1'b0;
        wr_fire  = 1'b0;
        rd_adv   = 1'b0;

        pop      = !empty && rd_ready_i;
        overflow = reg_wr_en_i && full && !pop;
`ifdef MEASURE_FIFO_DROP_OLDEST_EN
        // Writing over mem[wr_ptr] when full replaces the oldest word, so the read side steps past it.
        wr_fire  = reg_wr_en_i;
        rd_adv   = pop || overflow;
`else
        wr_fire  = reg_wr_en_i && !overflow;
        rd_adv   = pop;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || clr_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (wr_fire && !rd_adv) begin
                level <= level + LEVEL_ONE;
            end else if (rd_adv && !wr_fire) begin
                level <= level - LEVEL_ONE;
            end
            if (overflow) begin
                ovf <= 1'b1;
            end
        end
    end

    // Storage carries no reset; a write is simply suppressed while reset or flush is active.
    always_ff @(posedge clk_i) begin
        if (rst_n_i && !clr_i && wr_fire) begin
            mem[wr_ptr] <= reg_wr_data_i;
        end
    end

    assign rd_valid_o = !empty;
    assign rd_data_o  = mem[rd_ptr];
    assign level_o    = level;
    assign full_o     = full;
    assign empty_o    = empty;
    assign ovf_o      = ovf;

endmodule
